// File: rtl/data_bus_responder_pkg.sv
// Shared definitions for the data-memory bus responder: FSM encoding and
// address-map constants.
package data_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } bus_state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;
    localparam logic [1:0]  WORD_ALIGN_MASK   = 2'b11;

endpackage

// File: rtl/data_bus_responder_ram.sv
// Single-port synchronous word RAM with a registered read port.
// Only the read register is reset; stored contents survive reset.
module responder_ram #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 256,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/data_bus_responder.sv
// Responder end of the core's data-memory bus: handshake, wait states,
// range/alignment checking and a word RAM.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for req_i; request fields latched on acceptance
// ST_WAIT   | down-counting programmed wait states
// ST_ACCESS | RAM written (store) or read into data_o (load) at exit edge
// ST_RESP   | ready_o high for one cycle, error_o qualifies it
module data_bus_responder
    import data_bus_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          MEMORY_DEPTH = 256,
    parameter int          WAIT_STATES  = 2,
    parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_i,
    input  logic                  write_i,
    input  logic [31:0]           address_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  error_o,
    output logic                  busy_o
);

    localparam int          AW          = $clog2(MEMORY_DEPTH);
    localparam logic [31:0] RANGE_BYTES = 32'(MEMORY_DEPTH * 4);
    localparam logic [3:0]  WAIT_LOAD   = 4'(WAIT_STATES - 1);

    bus_state_t            state;
    logic                  wr_q;
    logic [AW-1:0]         idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            cnt_q;

    logic [31:0] offset;
    logic        req_err;

    // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
    assign offset  = address_i - BASE_ADDR;
    assign req_err = ((address_i[1:0] & WORD_ALIGN_MASK) != 2'b00) ||
                     (offset >= RANGE_BYTES);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            ready_o <= 1'b0;
            error_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        wr_q    <= write_i;
                        idx_q   <= offset[AW+1:2];
                        wdata_q <= write_data_i;
                        busy_o  <= 1'b1;
                        if (req_err) begin
                            state   <= ST_RESP;
                            ready_o <= 1'b1;
                            error_o <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            state <= ST_ACCESS;
                        end else begin
                            cnt_q <= WAIT_LOAD;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state <= ST_ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    state   <= ST_RESP;
                    ready_o <= 1'b1;
                    error_o <= 1'b0;
                end
                ST_RESP: begin
                    state   <= ST_IDLE;
                    ready_o <= 1'b0;
                    error_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_o <= 1'b0;
                    error_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    // Errored accesses never pass through ST_ACCESS, so they cannot touch the RAM.
    responder_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MEMORY_DEPTH(MEMORY_DEPTH),
        .ADDR_WIDTH  (AW)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we     ((state == ST_ACCESS) && wr_q),
        .re     ((state == ST_ACCESS) && !wr_q),
        .addr   (idx_q),
        .wdata  (wdata_q),
        .rd_data(data_o)
    );

endmodule
